code2de5_serial_rx: RTL
=======================

Name: code2de5_serial_rx

Overview:
- Serial receiver that sits directly upstream of the 2-of-5 seven-segment decoder.
- Deserializes one 2-of-5 code word per UART-style frame from a single input line and holds it on E1..E5.
- Flags whether the word is a legal code, meaning exactly two ones.
- Drives the decoder's S3 blanking input until the first frame has been accepted.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit. Legal values: 4 to 1024. Sample counter width is $clog2(CLKS_PER_BIT).

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- RX  input  1  serial line, idle high, asynchronous to CLK.
- E1  output  1  held code bit 1, the first data bit on the line.
- E2  output  1  held code bit 2.
- E3  output  1  held code bit 3.
- E4  output  1  held code bit 4.
- E5  output  1  held code bit 5, the last data bit.
- S3  output  1  blank request to the decoder. 1 = blank.
- VALID  output  1  held word has exactly two ones.
- NEW  output  1  one-cycle strobe when E1..E5/VALID are updated.
- FRAME_ERR  output  1  sticky: last frame had a bad stop bit.

Behaviour:
- Reset (asynchronous, RST_N=0): E1..E5=0, S3=1, VALID=0, NEW=0, FRAME_ERR=0, FSM=IDLE, counters=0, synchronizer flops=1.
- Frame format: 1 start bit (0), then 5 data bits in order E1 to E5, then 1 stop bit (1).
- RX passes through a 2-flop synchronizer before any use. All timing below is relative to the synchronized signal.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: a synchronized 0 goes to START and clears the cycle counter.
- START: at count CLKS_PER_BIT/2-1 (mid-bit), sample the line.
  - Sample is 0: go to DATA, bit index=0, counter cleared.
  - Sample is 1 (glitch): return to IDLE with no output change.
- DATA: sample every CLKS_PER_BIT cycles at mid-bit into a shift register, index 0 to 4. After index 4 is sampled, go to STOP.
- STOP: sample at mid-bit.
  - Sample is 1: on the next cycle, copy the shift register to E1..E5 and compute VALID as popcount==2. Pulse NEW for exactly 1 cycle, set S3=0, clear FRAME_ERR, go to IDLE.
  - Sample is 0: FRAME_ERR=1, E1..E5/VALID/S3 unchanged, NEW stays 0, go to WAIT_IDLE.
- WAIT_IDLE: stay until the synchronized line is 1, then go to IDLE. This prevents re-triggering on a held-low line.
- Latency: NEW rises 1 CLK after the stop-bit mid-sample. Start edge at RX to NEW is 2 (synchronizer) + 6.5*CLKS_PER_BIT + 1 cycles, ±1 for edge alignment.
- Outputs are registered and stable between NEW strobes. The decoder may consume them combinationally at any time.
- Back-to-back frames: a start bit immediately after the stop bit is accepted. IDLE is re-entered in the cycle after the stop sample, and half a bit time remains before the next start edge.
- Reset mid-frame: the frame is abandoned and all outputs return to reset values immediately. The first complete frame after release is received normally.
- S3 never returns to 1 except by reset.

Optional Feature:
- Macro: HOLD_LAST_VALID_EN.
- Defined: a frame with a good stop bit but popcount!=2 does not update E1..E5, which keep the last legal word. VALID goes to 0 and NEW still pulses. S3 is cleared only by the first legal word. The display therefore never shows the error pattern while a prior legal word exists.
- Undefined: every good-stop frame is latched as received, and the decoder shows its error pattern for illegal words.

Test Plan:
- Reset, then idle line for 100 cycles: expect E1..E5=00000, S3=1, VALID=0, NEW=0, FRAME_ERR=0.
- CLKS_PER_BIT=16, send start, bits 1,1,0,0,0, stop 1: expect a single NEW pulse about 107 cycles after the start edge, then E1..E5=11000, VALID=1, S3=0.
- Send bits 1,1,1,0,0 with a good stop:
  - Macro off: E1..E5=11100, VALID=0, NEW pulses.
  - Macro on: E1..E5 hold 11000, VALID=0, NEW pulses.
- Send bits 0,0,1,0,1 with stop bit 0, line then held low 50 cycles and released: FRAME_ERR=1, no NEW, E unchanged. The next good frame 0,1,0,1,0 gives E=01010, VALID=1, FRAME_ERR=0.
- 3-cycle low glitch on idle RX: no state advance past START, no NEW, outputs unchanged.
- Assert RST_N low during data bit 3 of a frame, release, then send 1,0,0,1,0: outputs reset at once. The following frame gives E=10010, VALID=1, S3=0.

Source files
------------

// File: rtl/code2de5_serial_rx_if.sv
// code2de5_serial_rx_if: serial line in, held 2-of-5 word and status out.
// The slave modport is the receiver side, the master modport is the line
// driver / decoder side. DBG_STATE exposes the receiver FSM state.
interface code2de5_serial_rx_if;
    logic       RX;
    logic       E1;
    logic       E2;
    logic       E3;
    logic       E4;
    logic       E5;
    logic       S3;
    logic       VALID;
    logic       NEW;
    logic       FRAME_ERR;
    logic [2:0] DBG_STATE;

    modport slave (
        input  RX,
        output E1, E2, E3, E4, E5, S3, VALID, NEW, FRAME_ERR, DBG_STATE
    );

    modport master (
        output RX,
        input  E1, E2, E3, E4, E5, S3, VALID, NEW, FRAME_ERR, DBG_STATE
    );
endinterface

// File: rtl/code2de5_serial_rx.sv
// code2de5_serial_rx: UART-style receiver for one 2-of-5 code word per frame.
// Frame: start(0), E1..E5, stop(1). Holds the last word on E1..E5, flags a
// legal word (exactly two ones) on VALID, strobes NEW on every update and
// holds S3 (blank) high until the first accepted frame.
// Optional build macro HOLD_LAST_VALID_EN: illegal words do not replace the
// held word, and only a legal word releases S3.
module code2de5_serial_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    code2de5_serial_rx_if.slave   bus
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_C = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_C = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_IDX = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_IDLE = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic             rx_meta_q, rx_sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [4:0]       shift_q, shift_d;

    logic [4:0]       word_q;
    logic             s3_q, valid_q, new_q, ferr_q;

    // FSM control decoded from state and counter
    logic             cnt_clr;
    logic             idx_clr;
    logic             bit_sample;
    logic             commit;
    logic             frame_bad;

    logic [2:0]       ones;
    logic             word_legal;

    // Two-flop synchronizer; idle level is high so reset to 1
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= bus.RX;
            rx_sync_q <= rx_meta_q;
        end
    end

    // FSM state register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!rx_sync_q) state_d = S_START;
            end
            S_START: begin
                // A high line at mid start bit was a glitch
                if (cnt_q == HALF_C) state_d = rx_sync_q ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (cnt_q == FULL_C && idx_q == LAST_IDX) state_d = S_STOP;
            end
            S_STOP: begin
                if (cnt_q == FULL_C) state_d = rx_sync_q ? S_IDLE : S_WAIT_IDLE;
            end
            S_WAIT_IDLE: begin
                // Do not re-arm on a line that is still held low
                if (rx_sync_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM control outputs
    always_comb begin
        cnt_clr    = 1'b0;
        idx_clr    = 1'b0;
        bit_sample = 1'b0;
        commit     = 1'b0;
        frame_bad  = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_clr = 1'b1;
            end
            S_START: begin
                if (cnt_q == HALF_C) begin
                    cnt_clr = 1'b1;
                    idx_clr = 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == FULL_C) begin
                    cnt_clr    = 1'b1;
                    bit_sample = 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_q == FULL_C) begin
                    cnt_clr   = 1'b1;
                    commit    = rx_sync_q;
                    frame_bad = !rx_sync_q;
                end
            end
            S_WAIT_IDLE: begin
                cnt_clr = 1'b1;
            end
            default: begin
                cnt_clr = 1'b1;
            end
        endcase
    end

    // Bit-timing counter, bit index and shift register next values
    always_comb begin
        cnt_d   = cnt_clr ? '0 : cnt_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        if (idx_clr) begin
            idx_d = '0;
        end
        if (bit_sample) begin
            // First data bit ends up in bit 4, which drives E1
            shift_d = {shift_q[3:0], rx_sync_q};
            idx_d   = idx_q + 3'd1;
        end
    end

    // Bit-timing counter, bit index and shift register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    // Legal 2-of-5 word: exactly two ones
    always_comb begin
        ones = {2'b00, shift_q[0]} + {2'b00, shift_q[1]} + {2'b00, shift_q[2]}
             + {2'b00, shift_q[3]} + {2'b00, shift_q[4]};
        word_legal = (ones == 3'd2);
    end

    // Held word and status registers, updated on the stop-bit sample
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            word_q  <= '0;
            s3_q    <= 1'b1;
            valid_q <= 1'b0;
            new_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            new_q <= 1'b0;
            if (commit) begin
`ifdef HOLD_LAST_VALID_EN
                // Keep showing the last legal word instead of an error pattern
                if (word_legal) begin
                    word_q <= shift_q;
                    s3_q   <= 1'b0;
                end
`else
                word_q <= shift_q;
                s3_q   <= 1'b0;
`endif
                valid_q <= word_legal;
                new_q   <= 1'b1;
                ferr_q  <= 1'b0;
            end else if (frame_bad) begin
                ferr_q <= 1'b1;
            end
        end
    end

    assign bus.E1        = word_q[4];
    assign bus.E2        = word_q[3];
    assign bus.E3        = word_q[2];
    assign bus.E4        = word_q[1];
    assign bus.E5        = word_q[0];
    assign bus.S3        = s3_q;
    assign bus.VALID     = valid_q;
    assign bus.NEW       = new_q;
    assign bus.FRAME_ERR = ferr_q;
    assign bus.DBG_STATE = state_q;

endmodule
